// File: rtl/wb_cmd_master_if.sv
// ---------------------------------------------------------------------------
// wb_cmd_master_if
//   Bundles the local command/response port and the Wishbone B4 pipelined
//   master signals of wb_cmd_master.
//
//   Command side : cmd_valid_i / cmd_ready_o handshake carrying we, adr, dat
//                  and sel.
//   Response side: rsp_valid_o one-cycle strobe with rsp_dat_o, rsp_err_o and
//                  rsp_timeout_o.
//   Wishbone side: cyc/stb/we/adr/sel/dat out; ack/err/rty/stall/dat in.
//
//   Modports:
//     master - the view used by wb_cmd_master itself
//     slave  - the mirrored view for the controller and the bus model
// ---------------------------------------------------------------------------
interface wb_cmd_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-1:0] cmd_adr_i;
    logic [31:0]           cmd_dat_i;
    logic [3:0]            cmd_sel_i;

    logic                  rsp_valid_o;
    logic [31:0]           rsp_dat_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [3:0]            wb_sel_o;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  wb_rty_i;
    logic                  wb_stall_i;
    logic [31:0]           wb_dat_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Single-outstanding Wishbone B4 pipelined initiator. One accepted command
//   becomes one bus transfer (with bounded re-issue on rty) and produces a
//   one-cycle response strobe.
//
//   Ports:
//     clk_i  - clock, all logic on the rising edge
//     rst_i  - synchronous active-high reset
//     bus    - wb_cmd_master_if.master: command port, response port and
//              Wishbone master signals
//
//   Parameters:
//     ADDR_WIDTH - address width of command and bus
//     RETRY_MAX  - re-issues allowed after rty before reporting an error
//     TIMEOUT    - cycles with cyc high before the transfer is aborted
//
//   Optional feature, macro WB_CMD_MASTER_TIMEOUT_EN:
//     defined   - 16-bit watchdog aborts a transfer after TIMEOUT cycles with
//                 cyc high and reports rsp_err_o=1, rsp_timeout_o=1
//     undefined - no watchdog; the block waits indefinitely, rsp_timeout_o=0
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int RETRY_MAX  = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_cmd_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [31:0]           dat_q;
    logic [3:0]            sel_q;

    logic [3:0]            retry_cnt;
    logic [3:0]            retry_cnt_nxt;

    logic [31:0]           rsp_dat_q;
    logic [31:0]           rsp_dat_nxt;
    logic                  rsp_err_q;
    logic                  rsp_err_nxt;
    logic                  rsp_to_q;
    logic                  rsp_to_nxt;

    logic                  accept;
    logic                  term_sample;
    logic                  timeout_hit;

    assign accept = (state == IDLE) && bus.cmd_valid_i;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt;

    // Counts every cycle with cyc high; retries do not restart it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if ((state == REQ) || (state == WAIT)) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // ">=" rather than "==": if a rty wins the limit cycle, the very next
    // cycle without a termination still aborts.
    assign timeout_hit = ((state == REQ) || (state == WAIT)) &&
                         (to_cnt >= TIMEOUT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // State, command copy and response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            retry_cnt <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_to_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_cnt_nxt;
            rsp_dat_q <= rsp_dat_nxt;
            rsp_err_q <= rsp_err_nxt;
            rsp_to_q  <= rsp_to_nxt;
            if (accept) begin
                we_q  <= bus.cmd_we_i;
                adr_q <= bus.cmd_adr_i;
                dat_q <= bus.cmd_dat_i;
                sel_q <= bus.cmd_sel_i;
            end
        end
    end

    // Next state and response capture
    always_comb begin
        state_nxt     = state;
        retry_cnt_nxt = retry_cnt;
        rsp_dat_nxt   = rsp_dat_q;
        rsp_err_nxt   = rsp_err_q;
        rsp_to_nxt    = rsp_to_q;
        // Terminations count in WAIT, or in REQ once the slave takes the stb.
        term_sample   = (state == WAIT) || ((state == REQ) && !bus.wb_stall_i);

        case (state)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    state_nxt = REQ;
                end
            end

            REQ, WAIT: begin
                if (term_sample && bus.wb_err_i) begin
                    state_nxt   = RESP;
                    rsp_err_nxt = 1'b1;
                    rsp_dat_nxt = '0;
                    rsp_to_nxt  = 1'b0;
                end else if (term_sample && bus.wb_ack_i) begin
                    state_nxt   = RESP;
                    rsp_err_nxt = 1'b0;
                    rsp_dat_nxt = we_q ? 32'd0 : bus.wb_dat_i;
                    rsp_to_nxt  = 1'b0;
                end else if (term_sample && bus.wb_rty_i) begin
                    if (retry_cnt < 4'(RETRY_MAX)) begin
                        retry_cnt_nxt = retry_cnt + 4'd1;
                        state_nxt     = REQ;
                    end else begin
                        state_nxt   = RESP;
                        rsp_err_nxt = 1'b1;
                        rsp_dat_nxt = '0;
                        rsp_to_nxt  = 1'b0;
                    end
                end else if (timeout_hit) begin
                    state_nxt   = RESP;
                    rsp_err_nxt = 1'b1;
                    rsp_dat_nxt = '0;
                    rsp_to_nxt  = 1'b1;
                end else if ((state == REQ) && !bus.wb_stall_i) begin
                    state_nxt = WAIT;
                end
            end

            RESP: begin
                state_nxt     = IDLE;
                retry_cnt_nxt = '0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; bus fields come straight from the copy
    assign bus.cmd_ready_o   = (state == IDLE);
    assign bus.rsp_valid_o   = (state == RESP);
    assign bus.rsp_dat_o     = rsp_dat_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.rsp_timeout_o = rsp_to_q;
    assign bus.wb_cyc_o      = (state == REQ) || (state == WAIT);
    assign bus.wb_stb_o      = (state == REQ);
    assign bus.wb_we_o       = we_q;
    assign bus.wb_adr_o      = adr_q;
    assign bus.wb_sel_o      = sel_q;
    assign bus.wb_dat_o      = dat_q;

endmodule
